// File: rtl/tour_cmd_pkg.sv
// tour_cmd_pkg: shared types and constants for the tour command sequencer.
//   state_e          - sequencer states
//   HEAD_*           - heading field values of a move command
//   OP_MOVE/OP_FANF  - opcode nibble of a move command (plain / with fanfare)
//   RESP_DONE/BUSY   - response bytes returned over Bluetooth
//   is_one_hot()     - helper used by the optional move legality check
package tour_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_e;

  localparam logic [7:0] HEAD_NORTH = 8'h00;
  localparam logic [7:0] HEAD_WEST  = 8'h3F;
  localparam logic [7:0] HEAD_SOUTH = 8'h7F;
  localparam logic [7:0] HEAD_EAST  = 8'hBF;

  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_FANF = 4'h3;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  function automatic logic is_one_hot(input logic [7:0] v);
    // v & (v-1) clears the lowest set bit; zero result with nonzero v means one bit
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// tour_move_decode: splits a one-hot knight move into two move commands.
//   move_q   in  8   one-hot knight move (lowest set bit wins; zero decodes as b0)
//   vert_cmd out 16  vertical leg: plain move, north/south, |dy| squares
//   horz_cmd out 16  horizontal leg: fanfare move, east/west, |dx| squares
module tour_move_decode
  import tour_cmd_pkg::*;
(
  input  logic [7:0]  move_q,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic [2:0] bit_idx;

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    bit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (move_q[i]) bit_idx = 3'(i);
    end
  end

  always_comb begin
    vert_cmd = {OP_MOVE, HEAD_NORTH, 4'd2};
    horz_cmd = {OP_FANF, HEAD_EAST, 4'd1};
    case (bit_idx)
      3'd0: begin vert_cmd = {OP_MOVE, HEAD_NORTH, 4'd2}; horz_cmd = {OP_FANF, HEAD_EAST, 4'd1}; end
      3'd1: begin vert_cmd = {OP_MOVE, HEAD_NORTH, 4'd2}; horz_cmd = {OP_FANF, HEAD_WEST, 4'd1}; end
      3'd2: begin vert_cmd = {OP_MOVE, HEAD_NORTH, 4'd1}; horz_cmd = {OP_FANF, HEAD_WEST, 4'd2}; end
      3'd3: begin vert_cmd = {OP_MOVE, HEAD_SOUTH, 4'd1}; horz_cmd = {OP_FANF, HEAD_WEST, 4'd2}; end
      3'd4: begin vert_cmd = {OP_MOVE, HEAD_SOUTH, 4'd2}; horz_cmd = {OP_FANF, HEAD_WEST, 4'd1}; end
      3'd5: begin vert_cmd = {OP_MOVE, HEAD_SOUTH, 4'd2}; horz_cmd = {OP_FANF, HEAD_EAST, 4'd1}; end
      3'd6: begin vert_cmd = {OP_MOVE, HEAD_SOUTH, 4'd1}; horz_cmd = {OP_FANF, HEAD_EAST, 4'd2}; end
      default: begin vert_cmd = {OP_MOVE, HEAD_NORTH, 4'd1}; horz_cmd = {OP_FANF, HEAD_EAST, 4'd2}; end
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// tour_cmd: knight's-tour command sequencer with UART/BLE passthrough when idle.
//   clk, rst                  clock, synchronous active-high reset
//   start_tour                pulse to begin walking the move list
//   move / mv_indx            solver memory data / index
//   cmd_UART, cmd_rdy_UART    command from UART wrapper (passed through in IDLE)
//   clr_cmd_rdy_UART          consume strobe back to UART wrapper (IDLE only)
//   cmd, cmd_rdy, clr_cmd_rdy command handshake to the command processor
//   send_resp, resp           completion from command processor / response byte
//   tour_err                  sticky illegal-move flag
// Optional feature macro: TOUR_CMD_MOVE_CHECK_EN enables the one-hot move check;
// when undefined tour_err is tied low.
module tour_cmd
  import tour_cmd_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_err
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_e      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [7:0]  move_q, move_d;
  logic [15:0] vert_cmd, horz_cmd;
  logic        move_bad;
  logic        last_move;

  tour_move_decode u_decode (
    .move_q   (move_q),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

`ifdef TOUR_CMD_MOVE_CHECK_EN
  logic tour_err_q, tour_err_d;

  assign move_bad = !is_one_hot(move);

  always_comb begin
    tour_err_d = tour_err_q;
    if (state_q == IDLE && start_tour) begin
      tour_err_d = 1'b0;
    end else if (state_q == LOAD && move_bad) begin
      tour_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tour_err_q <= 1'b0;
    else     tour_err_q <= tour_err_d;
  end

  assign tour_err = tour_err_q;
`else
  assign move_bad = 1'b0;
  assign tour_err = 1'b0;
`endif

  assign last_move = (mv_indx_q == LAST_IDX);
  assign mv_indx   = mv_indx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
      move_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      move_q    <= move_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    move_d           = move_q;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_BUSY;

    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) begin
          mv_indx_d = 5'd0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        move_d  = move;
        state_d = move_bad ? IDLE : VERT;
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_V;
      end
      WAIT_V: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        if (last_move) resp = RESP_DONE;
        if (send_resp) begin
          if (last_move) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
